// File: rtl/wave_generator.sv
// Phase-accumulator waveform generator: saw up/down, triangle and variable-duty square.
// Mode and duty only change on a period boundary (wrap) or on a sync restart.
module wave_generator #(
    parameter int OUT_WIDTH   = 8,
    parameter int PHASE_WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   enable,
    input  logic                   sync,
    input  logic [PHASE_WIDTH-1:0] phase_step,
    input  logic [1:0]             mode,
    input  logic [OUT_WIDTH-1:0]   duty,
    output logic [OUT_WIDTH-1:0]   wave_out,
    output logic                   wrap,
    output logic [1:0]             mode_active
);

    localparam logic [1:0] MODE_SAW_UP   = 2'd0;
    localparam logic [1:0] MODE_SAW_DOWN = 2'd1;
    localparam logic [1:0] MODE_TRIANGLE = 2'd2;
    localparam logic [OUT_WIDTH-1:0] DUTY_RESET = {1'b1, {(OUT_WIDTH-1){1'b0}}};

    logic [PHASE_WIDTH-1:0] phase_q, phase_d;
    logic [OUT_WIDTH-1:0]   wave_q, wave_d;
    logic                   wrap_q, wrap_d;
    logic [1:0]             mode_q, mode_d;
    logic [OUT_WIDTH-1:0]   duty_q, duty_d;

    logic [PHASE_WIDTH:0]   sum_w;
    logic [OUT_WIDTH-1:0]   t_w;
    logic [OUT_WIDTH-1:0]   t_shl_w;

    assign sum_w   = {1'b0, phase_q} + {1'b0, phase_step};
    assign t_w     = phase_q[PHASE_WIDTH-1 -: OUT_WIDTH];
    assign t_shl_w = {t_w[OUT_WIDTH-2:0], 1'b0};

    // sync beats enable; the carry out of the add is the period boundary.
    always_comb begin
        phase_d = phase_q;
        wrap_d  = 1'b0;
        mode_d  = mode_q;
        duty_d  = duty_q;
        if (sync) begin
            phase_d = '0;
            mode_d  = mode;
            duty_d  = duty;
        end else if (enable) begin
            phase_d = sum_w[PHASE_WIDTH-1:0];
            wrap_d  = sum_w[PHASE_WIDTH];
            if (sum_w[PHASE_WIDTH]) begin
                mode_d = mode;
                duty_d = duty;
            end
        end
    end

    // Sample shape comes from the pre-update phase, giving one cycle of latency.
    always_comb begin
        wave_d = '0;
        case (mode_q)
            MODE_SAW_UP:   wave_d = t_w;
            MODE_SAW_DOWN: wave_d = ~t_w;
            MODE_TRIANGLE: wave_d = t_w[OUT_WIDTH-1] ? ~t_shl_w : t_shl_w;
            default:       wave_d = (t_w < duty_q) ? {OUT_WIDTH{1'b1}} : '0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            phase_q <= '0;
            wave_q  <= '0;
            wrap_q  <= 1'b0;
            mode_q  <= 2'd0;
            duty_q  <= DUTY_RESET;
        end else begin
            phase_q <= phase_d;
            wave_q  <= wave_d;
            wrap_q  <= wrap_d;
            mode_q  <= mode_d;
            duty_q  <= duty_d;
        end
    end

    assign wave_out    = wave_q;
    assign wrap        = wrap_q;
    assign mode_active = mode_q;

endmodule

// File: tb/tb_wave_generator.sv
// Directed bench for wave_generator (OUT_WIDTH=8, PHASE_WIDTH=16): a vector table
// followed by multi-cycle sequences for periods, deferred mode/duty, sync, hold and reset.
module tb_wave_generator;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic        sync;
    logic [15:0] phase_step;
    logic [1:0]  mode;
    logic [7:0]  duty;
    logic [7:0]  wave_out;
    logic        wrap;
    logic [1:0]  mode_active;

    int checks = 0;
    int errors = 0;

    // Expected word: {mode_active, wrap, wave_out}
    logic [10:0] exp_q[$];

    typedef struct {
        logic        en;
        logic        sy;
        logic [15:0] step;
        logic [1:0]  mode;
        logic [7:0]  duty;
        logic [7:0]  exp_wave;
        logic        exp_wrap;
        logic [1:0]  exp_mode;
    } vec_t;

    vec_t vecs[18];

    wave_generator #(.OUT_WIDTH(8), .PHASE_WIDTH(16)) dut (
        .clk         (clk),
        .reset       (reset),
        .enable      (enable),
        .sync        (sync),
        .phase_step  (phase_step),
        .mode        (mode),
        .duty        (duty),
        .wave_out    (wave_out),
        .wrap        (wrap),
        .mode_active (mode_active)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Push the expected sample, clock once, then pop and compare.
    task automatic run_cycle(input string name, input logic [1:0] em, input logic ew, input logic [7:0] ev);
        logic [10:0] e;
        exp_q.push_back({em, ew, ev});
        tick();
        e = exp_q.pop_front();
        check(name, {21'd0, mode_active, wrap, wave_out}, {21'd0, e});
    endtask

    task automatic do_reset();
        reset = 1'b1;
        #1;
        check("reset_wave", {24'd0, wave_out}, 32'd0);
        check("reset_wrap", {31'd0, wrap}, 32'd0);
        check("reset_mode", {30'd0, mode_active}, 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic sync_to(input logic [1:0] m, input logic [7:0] d, input logic [15:0] s);
        sync = 1'b1; enable = 1'b1; mode = m; duty = d; phase_step = s;
        tick();
        sync = 1'b0;
    endtask

    function automatic logic [7:0] tri_of(input int t);
        return (t < 128) ? 8'(2 * t) : 8'(511 - 2 * t);
    endfunction

    task automatic saw_up_run(input int n_cycles);
        for (int n = 0; n < n_cycles; n++)
            run_cycle("saw_up", 2'd0, (n % 256) == 255, 8'(n % 256));
    endtask

    initial begin
        reset = 1'b1; enable = 1'b0; sync = 1'b0; phase_step = '0; mode = '0; duty = '0;

        vecs[0]  = '{1'b1, 1'b0, 16'h4000, 2'd2, 8'h00, 8'h00, 1'b0, 2'd0};
        vecs[1]  = '{1'b1, 1'b0, 16'h4000, 2'd2, 8'h00, 8'h40, 1'b0, 2'd0};
        vecs[2]  = '{1'b1, 1'b0, 16'h4000, 2'd2, 8'h00, 8'h80, 1'b0, 2'd0};
        vecs[3]  = '{1'b1, 1'b0, 16'h4000, 2'd2, 8'h00, 8'hC0, 1'b1, 2'd2};
        vecs[4]  = '{1'b1, 1'b0, 16'h4000, 2'd3, 8'h80, 8'h00, 1'b0, 2'd2};
        vecs[5]  = '{1'b1, 1'b0, 16'h4000, 2'd3, 8'h80, 8'h80, 1'b0, 2'd2};
        vecs[6]  = '{1'b1, 1'b0, 16'h4000, 2'd3, 8'h80, 8'hFF, 1'b0, 2'd2};
        vecs[7]  = '{1'b1, 1'b0, 16'h4000, 2'd3, 8'h80, 8'h7F, 1'b1, 2'd3};
        vecs[8]  = '{1'b1, 1'b0, 16'h2000, 2'd3, 8'h80, 8'hFF, 1'b0, 2'd3};
        vecs[9]  = '{1'b0, 1'b0, 16'h2000, 2'd3, 8'h80, 8'hFF, 1'b0, 2'd3};
        vecs[10] = '{1'b0, 1'b0, 16'h2000, 2'd3, 8'h80, 8'hFF, 1'b0, 2'd3};
        vecs[11] = '{1'b1, 1'b0, 16'h6000, 2'd3, 8'h80, 8'hFF, 1'b0, 2'd3};
        vecs[12] = '{1'b1, 1'b0, 16'h0000, 2'd3, 8'h80, 8'h00, 1'b0, 2'd3};
        vecs[13] = '{1'b1, 1'b1, 16'h0000, 2'd1, 8'h00, 8'h00, 1'b0, 2'd1};
        vecs[14] = '{1'b1, 1'b0, 16'h8000, 2'd0, 8'h00, 8'hFF, 1'b0, 2'd1};
        vecs[15] = '{1'b1, 1'b1, 16'h8000, 2'd0, 8'h00, 8'h7F, 1'b0, 2'd0};
        vecs[16] = '{1'b1, 1'b0, 16'h0100, 2'd3, 8'h00, 8'h00, 1'b0, 2'd0};
        vecs[17] = '{1'b1, 1'b0, 16'h0100, 2'd3, 8'h00, 8'h01, 1'b0, 2'd0};

        repeat (2) @(posedge clk);
        do_reset();

        foreach (vecs[i]) begin
            enable = vecs[i].en; sync = vecs[i].sy; phase_step = vecs[i].step;
            mode = vecs[i].mode; duty = vecs[i].duty;
            run_cycle($sformatf("vec%0d", i), vecs[i].exp_mode, vecs[i].exp_wrap, vecs[i].exp_wave);
        end
        sync = 1'b0;

        // Fresh start: sawtooth up, wrap once per 256 samples.
        reset = 1'b1; enable = 1'b1; phase_step = 16'h0100; mode = 2'd0; duty = 8'd0;
        do_reset();
        saw_up_run(300);

        // Sawtooth down, then half step so each value holds two cycles.
        sync_to(2'd1, 8'd0, 16'h0100);
        for (int n = 0; n < 256; n++)
            run_cycle("saw_down", 2'd1, n == 255, 8'(255 - n));
        sync_to(2'd1, 8'd0, 16'h0080);
        for (int n = 0; n < 100; n++)
            run_cycle("saw_down_half", 2'd1, 1'b0, 8'(255 - n / 2));

        // Triangle over one full period plus the restart sample.
        sync_to(2'd2, 8'd0, 16'h0100);
        for (int n = 0; n < 257; n++)
            run_cycle("triangle", 2'd2, n == 255, tri_of(n % 256));

        // Square duty 64; mode/duty change mid-period waits for the wrap.
        sync_to(2'd3, 8'd64, 16'h0100);
        for (int n = 0; n < 300; n++) begin
            if (n == 100) begin
                mode = 2'd0; duty = 8'd192;
            end
            if (n <= 255)
                run_cycle("square_latch", (n < 255) ? 2'd3 : 2'd0, n == 255, (n < 64) ? 8'hFF : 8'h00);
            else
                run_cycle("square_latch", 2'd0, 1'b0, 8'(n - 256));
        end

        // Duty extremes: maximum gives a single low sample, zero gives none high.
        sync_to(2'd3, 8'd255, 16'h0100);
        for (int n = 0; n < 256; n++)
            run_cycle("duty_max", 2'd3, n == 255, (n < 255) ? 8'hFF : 8'h00);
        sync_to(2'd3, 8'd0, 16'h0100);
        for (int n = 0; n < 256; n++)
            run_cycle("duty_zero", 2'd3, n == 255, 8'h00);

        // sync at P=0x3700 with triangle pending, then a 10-cycle enable hold.
        sync_to(2'd0, 8'd0, 16'h0100);
        for (int n = 0; n < 'h37; n++)
            run_cycle("pre_sync", 2'd0, 1'b0, 8'(n));
        sync = 1'b1; mode = 2'd2;
        run_cycle("sync_edge", 2'd2, 1'b0, 8'h37);
        sync = 1'b0;
        for (int n = 0; n < 5; n++)
            run_cycle("post_sync", 2'd2, 1'b0, 8'(2 * n));
        enable = 1'b0;
        for (int n = 0; n < 10; n++)
            run_cycle("hold", 2'd2, 1'b0, 8'd10);
        enable = 1'b1;

        // Asynchronous reset mid-period at P=0xA000.
        sync_to(2'd2, 8'd0, 16'h0100);
        for (int n = 0; n < 'hA0; n++)
            run_cycle("pre_reset", 2'd2, 1'b0, tri_of(n));
        #2;
        mode = 2'd0;
        do_reset();
        saw_up_run(260);

        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL exp_q_drain: got %0d expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
